regfile_shift_unit: RTL and testbench
=====================================

// Module: regfile_shift_unit
// PURPOSE
//  Datapath block for the 64-bit multicycle RISC-V core. It contains the 32x64 integer register file.
//  It also contains the immediate shifter that feeds the MemToReg mux.
//  Two combinational read ports (rs1/rs2) feed the RegA/RegB latches; one synchronous write port.
//  The shift amount is taken from the instruction shamt field; the shifter operates on rs1 read data.
//  This is the shift path for SLLI, SRLI and SRAI.
// PARAMETERS
//  XLEN   64  data width of registers and shifter
//  NREGS  32  register count; index width = $clog2(NREGS) = 5
// PORTS
//  Clk        in   1     single clock, rising edge
//  Reset      in   1     asynchronous, active-low; clears all registers
//  RegWrite   in   1     write enable for the write port
//  ReadReg1   in   5     rs1 index
//  ReadReg2   in   5     rs2 index
//  WriteReg   in   5     rd index
//  WriteData  in   64    rd write data
//  Instr      in   32    current instruction word (from IR)
//  Shift      in   2     shift op: 00 SLL, 01 SRL, 10 SRA, 11 pass
//  ReadData1  out  64    rs1 contents (combinational)
//  ReadData2  out  64    rs2 contents (combinational)
//  ShiftN     out  6     shamt = Instr[25:20]
//  ShiftOut   out  64    ReadData1 shifted by ShiftN per Shift
// BEHAVIOUR
//  Reset
//   - Reset=0 asynchronously clears x0..x31 to 0, regardless of Clk.
//   - While Reset=0, writes are ignored and both read ports return 0.
//   - Release is sampled at the next Clk rising edge.
//  Write
//   - On Clk rising edge with Reset=1 and RegWrite=1: regs[WriteReg] <= WriteData.
//   - A write with WriteReg=0 is discarded; x0 always reads 0.
//  Read
//   - Both read ports are purely combinational: ReadDataN = (ReadRegN==0) ? 0 : regs[ReadRegN].
//   - No write-to-read bypass: a same-cycle read of rd returns the old value.
//   - The new value is visible after the edge.
//   - Both ports may address the same register simultaneously.
//  ShiftN
//   - Combinational ShiftN = Instr[25:20], the 6-bit RV64 shamt.
//   - Instr[31:26] is ignored here.
//  Shifter (combinational, 0-cycle latency)
//   - 00: ShiftOut = ReadData1 << ShiftN (zero-fill).
//   - 01: ShiftOut = ReadData1 >> ShiftN (zero-fill).
//   - 10: ShiftOut = ReadData1 >>> ShiftN (sign-fill from bit 63).
//   - 11: ShiftOut = ReadData1 unchanged.
//   - ShiftN=0 gives ReadData1 for every op.
//   - ShiftN=63 is the maximum shift; no wrap-around, no overflow flag.
//  Timing and outputs
//   - No handshake.
//   - Outputs are never X after reset; reset value of all outputs is 0 except ShiftN, which tracks Instr.
// STRUCTURE
//  Shared package core_pkg holds:
//   - XLEN, NREGS and REG_IDX_W.
//   - typedef enum logic [1:0] shift_op_t {SH_SLL=0, SH_SRL=1, SH_SRA=2, SH_PASS=3}.
//  One sub-module is natural: barrel_shifter64.
//   - Inputs: data, amount[5:0], shift_op_t.
//   - Built as a 6-stage log shifter.
//  The register array, the shamt extraction and the x0 masking stay in the top module.
// TESTING
//  1. Reset=0 mid-run after writing x5=0xDEAD -> x5 and all registers read 0 immediately, without waiting for an edge.
//  2. Write x7=0x0123_4567_89AB_CDEF, then read ReadReg1=7 and ReadReg2=7 -> both read 0x0123456789ABCDEF.
//     In the write cycle itself, the old value (0) is read.
//  3. RegWrite=1, WriteReg=0, WriteData=0xFFFF... -> ReadReg1=0 still reads 0.
//     RegWrite=0 with WriteReg=3 -> x3 is unchanged.
//  4. x1=0x8000_0000_0000_00F0 with Instr[25:20]=4:
//     - SLL -> 0x0000_0000_0000_0F00.
//     - SRL -> 0x0800_0000_0000_000F.
//     - SRA -> 0xF800_0000_0000_000F.
//     - PASS -> unchanged.
//  5. Instr=0x03F0D093 (srli-style, shamt=63) with x1=0x8000_0000_0000_0000:
//     - ShiftN=63.
//     - SRL -> 0x1.
//     - SRA -> 0xFFFF_FFFF_FFFF_FFFF.
//     - SLL -> 0.
//  6. Random regression: 1000 random write/read/shift ops checked against a reference model.
//     Coverage: every register index, every shift op, shamt 0 and 63.

Source files
------------

// File: rtl/core_pkg.sv
// Shared definitions for the 64-bit multicycle RISC-V datapath.
// Holds the data width, register count, register index width, shamt width
// and the shift operation encoding used by the immediate shifter.
package core_pkg;

    localparam int XLEN      = 64;
    localparam int NREGS     = 32;
    localparam int REG_IDX_W = $clog2(NREGS);
    localparam int SHAMT_W   = $clog2(XLEN);

    typedef enum logic [1:0] {
        SH_SLL  = 2'd0,
        SH_SRL  = 2'd1,
        SH_SRA  = 2'd2,
        SH_PASS = 2'd3
    } shift_op_t;

endpackage : core_pkg

// File: rtl/regfile_shift_unit_if.sv
// Bundle of the register file / shifter datapath signals.
//   RegWrite, ReadReg1, ReadReg2, WriteReg, WriteData, Instr, Shift : control side -> unit
//   ReadData1, ReadData2, ShiftN, ShiftOut                           : unit -> control side
// master : the controller/datapath driving the unit (or a testbench)
// slave  : the regfile_shift_unit itself
interface regfile_shift_unit_if;
    import core_pkg::*;

    logic                 RegWrite;
    logic [REG_IDX_W-1:0] ReadReg1;
    logic [REG_IDX_W-1:0] ReadReg2;
    logic [REG_IDX_W-1:0] WriteReg;
    logic [XLEN-1:0]      WriteData;
    logic [31:0]          Instr;
    shift_op_t            Shift;
    logic [XLEN-1:0]      ReadData1;
    logic [XLEN-1:0]      ReadData2;
    logic [SHAMT_W-1:0]   ShiftN;
    logic [XLEN-1:0]      ShiftOut;

    modport master (
        output RegWrite, ReadReg1, ReadReg2, WriteReg, WriteData, Instr, Shift,
        input  ReadData1, ReadData2, ShiftN, ShiftOut
    );

    modport slave (
        input  RegWrite, ReadReg1, ReadReg2, WriteReg, WriteData, Instr, Shift,
        output ReadData1, ReadData2, ShiftN, ShiftOut
    );

endinterface : regfile_shift_unit_if

// File: rtl/barrel_shifter64.sv
// Combinational 64-bit logarithmic barrel shifter for SLLI/SRLI/SRAI.
// Ports:
//   data   in  64  value to shift
//   amount in  6   shift distance 0..63
//   op     in  2   SH_SLL / SH_SRL / SH_SRA / SH_PASS
//   result out 64  shifted value
// Six stages; stage i shifts by 2**i when amount[i] is set, so any
// distance 0..63 is the composition of at most six fixed shifts.
module barrel_shifter64
    import core_pkg::*;
(
    input  logic [XLEN-1:0]    data,
    input  logic [SHAMT_W-1:0] amount,
    input  shift_op_t          op,
    output logic [XLEN-1:0]    result
);

    logic [XLEN-1:0] stage [SHAMT_W+1];

    always_comb begin
        for (int i = 0; i <= SHAMT_W; i++) begin
            stage[i] = '0;
        end
        stage[0] = data;
        for (int i = 0; i < SHAMT_W; i++) begin
            if (amount[i]) begin
                unique case (op)
                    SH_SLL:  stage[i+1] = stage[i] << (1 << i);
                    SH_SRL:  stage[i+1] = stage[i] >> (1 << i);
                    // Arithmetic stage replicates bit 63 into the vacated bits
                    SH_SRA:  stage[i+1] = $unsigned($signed(stage[i]) >>> (1 << i));
                    default: stage[i+1] = stage[i];
                endcase
            end else begin
                stage[i+1] = stage[i];
            end
        end
        result = (op == SH_PASS) ? data : stage[SHAMT_W];
    end

endmodule : barrel_shifter64

// File: rtl/regfile_shift_unit.sv
// 32x64 integer register file plus immediate shifter for the multicycle core.
// Ports:
//   Clk    in  1   rising-edge clock
//   Reset  in  1   asynchronous active-low; clears x0..x31
//   bus    slave modport of regfile_shift_unit_if:
//            RegWrite/WriteReg/WriteData  synchronous write port (x0 writes dropped)
//            ReadReg1/ReadReg2            combinational read indices
//            Instr/Shift                  shamt source and shift op
//            ReadData1/ReadData2          read data (0 while in reset or for x0)
//            ShiftN                       Instr[25:20]
//            ShiftOut                     ReadData1 shifted by ShiftN
module regfile_shift_unit
    import core_pkg::*;
(
    input  logic                 Clk,
    input  logic                 Reset,
    regfile_shift_unit_if.slave  bus
);

    logic [XLEN-1:0]    regs [NREGS];
    logic [XLEN-1:0]    read_data1;
    logic [XLEN-1:0]    read_data2;
    logic [SHAMT_W-1:0] shamt;
    logic               unused_instr_bits;

    // Register array: async clear, single write port, x0 never written
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (bus.RegWrite && (bus.WriteReg != '0)) begin
            regs[bus.WriteReg] <= bus.WriteData;
        end
    end

    // Reads are forced to zero during reset so the ports never expose
    // stale contents while the clear is still propagating.
    always_comb begin
        read_data1 = '0;
        read_data2 = '0;
        if (Reset && (bus.ReadReg1 != '0)) begin
            read_data1 = regs[bus.ReadReg1];
        end
        if (Reset && (bus.ReadReg2 != '0)) begin
            read_data2 = regs[bus.ReadReg2];
        end
    end

    // RV64 shamt is six bits; the funct6 bits above it select the op
    // elsewhere and are not used here.
    assign shamt             = bus.Instr[25:20];
    assign unused_instr_bits = ^{bus.Instr[31:26], bus.Instr[19:0]};

    barrel_shifter64 u_shifter (
        .data   (read_data1),
        .amount (shamt),
        .op     (bus.Shift),
        .result (bus.ShiftOut)
    );

    assign bus.ReadData1 = read_data1;
    assign bus.ReadData2 = read_data2;
    assign bus.ShiftN    = shamt;

endmodule : regfile_shift_unit

// File: tb/tb_regfile_shift_unit.sv
// Self-checking bench for regfile_shift_unit: directed scenarios followed by
// a randomized regression against a behavioural register/shift model.
module tb_regfile_shift_unit;
    import core_pkg::*;

    logic Clk;
    logic Reset;
    int   compared;
    int   mismatched;

    logic [63:0] model_regs [32];

    regfile_shift_unit_if bus ();

    regfile_shift_unit dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Reference read: x0 and anything during reset reads zero
    function automatic logic [63:0] ref_read(input logic [4:0] idx, input logic rst_n);
        if (!rst_n || idx == 5'd0) return 64'd0;
        return model_regs[idx];
    endfunction

    // Reference shift built from plain logical shifts and masks
    function automatic logic [63:0] ref_shift(input logic [63:0] val, input int amt,
                                              input shift_op_t op);
        logic [63:0] ones;
        ones = '1;
        case (op)
            SH_SLL:  return val << amt;
            SH_SRL:  return val >> amt;
            SH_SRA:  return (val >> amt) | (val[63] ? ~(ones >> amt) : 64'd0);
            default: return val;
        endcase
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 32; i++) model_regs[i] = 64'd0;
    endtask

    task automatic idle_inputs();
        bus.RegWrite  = 1'b0;
        bus.ReadReg1  = 5'd0;
        bus.ReadReg2  = 5'd0;
        bus.WriteReg  = 5'd0;
        bus.WriteData = 64'd0;
        bus.Instr     = 32'd0;
        bus.Shift     = SH_PASS;
    endtask

    // Single write, landing on the next rising edge; returns #1 after it
    task automatic write_reg(input logic [4:0] idx, input logic [63:0] val);
        bus.RegWrite  = 1'b1;
        bus.WriteReg  = idx;
        bus.WriteData = val;
        @(posedge Clk);
        if (idx != 5'd0) model_regs[idx] = val;
        #1;
        bus.RegWrite = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        idle_inputs();
        clear_model();
        bus.Instr    = 32'h0150_0013;
        bus.ReadReg1 = 5'd5;
        bus.ReadReg2 = 5'd31;
        bus.Shift    = SH_PASS;
        #2;
        if (bus.ReadData1 !== 64'd0) begin
            mismatched++;
            $display("[TB] FAIL reset_rd1 got=%h exp=%h", bus.ReadData1, 64'd0);
        end
        compared++;
        if (bus.ReadData2 !== 64'd0) begin
            mismatched++;
            $display("[TB] FAIL reset_rd2 got=%h exp=%h", bus.ReadData2, 64'd0);
        end
        compared++;
        if (bus.ShiftOut !== 64'd0) begin
            mismatched++;
            $display("[TB] FAIL reset_shiftout got=%h exp=%h", bus.ShiftOut, 64'd0);
        end
        compared++;
        if (bus.ShiftN !== 6'd21) begin
            mismatched++;
            $display("[TB] FAIL reset_shiftn got=%0d exp=%0d", bus.ShiftN, 21);
        end
        compared++;
        repeat (2) @(posedge Clk);
        #1;
        Reset = 1'b1;
        @(posedge Clk);
        #1;
    endtask

    task automatic test_write_read();
        logic [63:0] val;
        val = 64'h0123_4567_89AB_CDEF;
        bus.ReadReg1  = 5'd7;
        bus.ReadReg2  = 5'd7;
        bus.RegWrite  = 1'b1;
        bus.WriteReg  = 5'd7;
        bus.WriteData = val;
        #1;
        if (bus.ReadData1 !== 64'd0) begin
            mismatched++;
            $display("[TB] FAIL no_bypass_rd1 got=%h exp=%h", bus.ReadData1, 64'd0);
        end
        compared++;
        @(posedge Clk);
        model_regs[7] = val;
        #1;
        bus.RegWrite = 1'b0;
        #1;
        if (bus.ReadData1 !== val) begin
            mismatched++;
            $display("[TB] FAIL write_rd1 got=%h exp=%h", bus.ReadData1, val);
        end
        compared++;
        if (bus.ReadData2 !== val) begin
            mismatched++;
            $display("[TB] FAIL write_rd2 got=%h exp=%h", bus.ReadData2, val);
        end
        compared++;
    endtask

    task automatic test_x0_and_disable();
        write_reg(5'd0, 64'hFFFF_FFFF_FFFF_FFFF);
        bus.ReadReg1 = 5'd0;
        #1;
        if (bus.ReadData1 !== 64'd0) begin
            mismatched++;
            $display("[TB] FAIL x0_write got=%h exp=%h", bus.ReadData1, 64'd0);
        end
        compared++;
        write_reg(5'd3, 64'h1111_2222_3333_4444);
        bus.RegWrite  = 1'b0;
        bus.WriteReg  = 5'd3;
        bus.WriteData = 64'hAAAA_BBBB_CCCC_DDDD;
        @(posedge Clk);
        #1;
        bus.ReadReg2 = 5'd3;
        #1;
        if (bus.ReadData2 !== 64'h1111_2222_3333_4444) begin
            mismatched++;
            $display("[TB] FAIL regwrite_off got=%h exp=%h", bus.ReadData2, 64'h1111_2222_3333_4444);
        end
        compared++;
    endtask

    task automatic test_shift_ops();
        logic [63:0] exp [4];
        exp[0] = 64'h0000_0000_0000_0F00;
        exp[1] = 64'h0800_0000_0000_000F;
        exp[2] = 64'hF800_0000_0000_000F;
        exp[3] = 64'h8000_0000_0000_00F0;
        write_reg(5'd1, 64'h8000_0000_0000_00F0);
        bus.ReadReg1 = 5'd1;
        bus.Instr    = 32'h0040_9093;
        for (int op = 0; op < 4; op++) begin
            bus.Shift = shift_op_t'(op);
            #1;
            if (bus.ShiftOut !== exp[op]) begin
                mismatched++;
                $display("[TB] FAIL shift4_op%0d got=%h exp=%h", op, bus.ShiftOut, exp[op]);
            end
            compared++;
        end
    endtask

    task automatic test_shamt_max();
        logic [63:0] exp [3];
        exp[0] = 64'h0000_0000_0000_0001;
        exp[1] = 64'hFFFF_FFFF_FFFF_FFFF;
        exp[2] = 64'h0000_0000_0000_0000;
        write_reg(5'd1, 64'h8000_0000_0000_0000);
        bus.ReadReg1 = 5'd1;
        bus.Instr    = 32'h03F0_D093;
        #1;
        if (bus.ShiftN !== 6'd63) begin
            mismatched++;
            $display("[TB] FAIL shamt63_shiftn got=%0d exp=%0d", bus.ShiftN, 63);
        end
        compared++;
        for (int k = 0; k < 3; k++) begin
            bus.Shift = (k == 0) ? SH_SRL : (k == 1) ? SH_SRA : SH_SLL;
            #1;
            if (bus.ShiftOut !== exp[k]) begin
                mismatched++;
                $display("[TB] FAIL shamt63_case%0d got=%h exp=%h", k, bus.ShiftOut, exp[k]);
            end
            compared++;
        end
    endtask

    task automatic test_reset_midrun();
        write_reg(5'd5, 64'h0000_0000_0000_DEAD);
        bus.ReadReg1 = 5'd5;
        #1;
        if (bus.ReadData1 !== 64'hDEAD) begin
            mismatched++;
            $display("[TB] FAIL pre_reset_x5 got=%h exp=%h", bus.ReadData1, 64'hDEAD);
        end
        compared++;
        Reset = 1'b0;
        clear_model();
        #1;
        if (bus.ReadData1 !== 64'd0) begin
            mismatched++;
            $display("[TB] FAIL async_reset_x5 got=%h exp=%h", bus.ReadData1, 64'd0);
        end
        compared++;
        for (int i = 0; i < 32; i++) begin
            bus.ReadReg1 = 5'(i);
            bus.ReadReg2 = 5'(31 - i);
            #1;
            if (bus.ReadData1 !== 64'd0 || bus.ReadData2 !== 64'd0) begin
                mismatched++;
                $display("[TB] FAIL reset_clear_x%0d got=%h/%h exp=0", i, bus.ReadData1, bus.ReadData2);
            end
            compared++;
        end
        // Write attempted while held in reset must be dropped
        @(posedge Clk);
        #1;
        bus.RegWrite  = 1'b1;
        bus.WriteReg  = 5'd9;
        bus.WriteData = 64'h5A5A_5A5A_5A5A_5A5A;
        @(posedge Clk);
        #1;
        bus.RegWrite = 1'b0;
        Reset        = 1'b1;
        bus.ReadReg1 = 5'd9;
        bus.ReadReg2 = 5'd5;
        #1;
        if (bus.ReadData1 !== 64'd0 || bus.ReadData2 !== 64'd0) begin
            mismatched++;
            $display("[TB] FAIL write_in_reset got=%h/%h exp=0", bus.ReadData1, bus.ReadData2);
        end
        compared++;
        @(posedge Clk);
        #1;
    endtask

    task automatic test_random();
        logic [63:0] exp_rd1;
        logic [63:0] exp_rd2;
        logic [63:0] exp_sh;
        logic [5:0]  amt;
        for (int i = 0; i < 1000; i++) begin
            bus.RegWrite  = ($urandom_range(0, 9) < 7);
            bus.WriteReg  = 5'($urandom_range(0, 31));
            bus.WriteData = {$urandom, $urandom};
            bus.ReadReg1  = 5'(i % 32);
            bus.ReadReg2  = 5'($urandom_range(0, 31));
            bus.Shift     = shift_op_t'(i % 4);
            if (i % 8 == 0)      amt = 6'd0;
            else if (i % 8 == 1) amt = 6'd63;
            else                 amt = 6'($urandom_range(0, 63));
            bus.Instr = $urandom;
            bus.Instr[25:20] = amt;
            #1;
            exp_rd1 = ref_read(bus.ReadReg1, 1'b1);
            exp_rd2 = ref_read(bus.ReadReg2, 1'b1);
            exp_sh  = ref_shift(exp_rd1, int'(amt), shift_op_t'(i % 4));
            if (bus.ReadData1 !== exp_rd1 || bus.ReadData2 !== exp_rd2) begin
                mismatched++;
                $display("[TB] FAIL rand_read it=%0d got=%h/%h exp=%h/%h",
                         i, bus.ReadData1, bus.ReadData2, exp_rd1, exp_rd2);
            end
            compared++;
            if (bus.ShiftN !== amt || bus.ShiftOut !== exp_sh) begin
                mismatched++;
                $display("[TB] FAIL rand_shift it=%0d op=%0d n=%0d got=%h exp=%h",
                         i, i % 4, bus.ShiftN, bus.ShiftOut, exp_sh);
            end
            compared++;
            @(posedge Clk);
            if (bus.RegWrite && bus.WriteReg != 5'd0) model_regs[bus.WriteReg] = bus.WriteData;
            #1;
        end
        bus.RegWrite = 1'b0;
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        test_reset();
        test_write_read();
        test_x0_and_disable();
        test_shift_ops();
        test_shamt_max();
        test_reset_midrun();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule : tb_regfile_shift_unit
